iq_demod_multi: RTL

Parametrised multi-channel I/Q lock-in demodulator, the next generation of the single-channel phase detector. Each of NUM_CH ADC channels is multiplied by a shared in-phase/quadrature reference pair. Products are accumulated with saturation over a window closed either by a trigger edge or by a programmable sample count. Per-channel I/Q sums are delivered on a valid/ready output with sample count, saturation and overrun status. Sits between the ADC capture path and the phase/magnitude (CORDIC) stage.

---
 rtl/iq_demod_multi.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/iq_demod_multi.sv
// Multi-channel I/Q lock-in demodulator: shared I/Q reference products per
// channel, saturating window accumulation, valid/ready result delivery.
module iq_demod_multi #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned SIG_W  = 12,
    parameter int unsigned REF_W  = 8,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned CNT_W  = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    mode,
    input  logic [CNT_W-1:0]        win_len,
    input  logic                    trigger,
    input  logic                    in_valid,
    input  logic [NUM_CH*SIG_W-1:0] signal,
    input  logic [REF_W-1:0]        ref_i,
    input  logic [REF_W-1:0]        ref_q,
    output logic [NUM_CH*ACC_W-1:0] i_out,
    output logic [NUM_CH*ACC_W-1:0] q_out,
    output logic [CNT_W-1:0]        count_out,
    output logic [NUM_CH-1:0]       sat_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);
    localparam int unsigned PROD_W = SIG_W + REF_W;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t state;
    state_t state_next;
    logic   start_c;
    logic   run_c;
    logic   last_c;
    logic   trigger_d;
    logic   trig_rise;

    logic [CNT_W-1:0] win_len_eff;
    logic [CNT_W-1:0] win_len_lat;
    logic [CNT_W-1:0] sample_cnt;

    logic [NUM_CH-1:0][PROD_W-1:0] prod_i;
    logic [NUM_CH-1:0][PROD_W-1:0] prod_q;
    logic                          p_valid;
    logic                          p_last;

    logic [NUM_CH-1:0][ACC_W-1:0] acc_i;
    logic [NUM_CH-1:0][ACC_W-1:0] acc_q;
    logic [NUM_CH-1:0][ACC_W-1:0] sum_i_c;
    logic [NUM_CH-1:0][ACC_W-1:0] sum_q_c;
    logic [NUM_CH-1:0]            clamp_c;
    logic [NUM_CH-1:0]            sat_acc;
    logic [CNT_W-1:0]             win_cnt;
    logic [ACC_W:0]               res_i;
    logic [ACC_W:0]               res_q;

    // Saturating add; returns {clamped, value}
    function automatic logic [ACC_W:0] add_sat(input logic [ACC_W-1:0] a,
                                               input logic [PROD_W-1:0] p,
                                               input logic add);
        logic signed [SUM_W-1:0] s;
        logic [ACC_W-1:0]        v;
        s = $signed({a[ACC_W-1], a}) + (add ? SUM_W'($signed(p)) : SUM_W'(0));
        if (s[ACC_W] != s[ACC_W-1]) v = s[ACC_W] ? ACC_MIN : ACC_MAX;
        else                        v = s[ACC_W-1:0];
        return {s[ACC_W] ^ s[ACC_W-1], v};
    endfunction

    assign trig_rise   = trigger & ~trigger_d;
    assign win_len_eff = (win_len == '0) ? CNT_W'(1) : win_len;
    assign last_c      = run_c & (mode ? (in_valid && (sample_cnt == win_len_lat - CNT_W'(1)))
                                       : trig_rise);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: disable always returns to IDLE
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (mode || trig_rise) state_next = ACCUM;
                ACCUM:   state_next = ACCUM;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM decode: window start and accumulate qualifiers
    always_comb begin
        start_c = 1'b0;
        run_c   = 1'b0;
        if (enable) begin
            case (state)
                IDLE:    start_c = (state_next == ACCUM);
                ACCUM:   run_c   = 1'b1;
                default: ;
            endcase
        end
    end

    // Stage 1: trigger delay, products, window-close detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trigger_d   <= 1'b0;
            prod_i      <= '0;
            prod_q      <= '0;
            p_valid     <= 1'b0;
            p_last      <= 1'b0;
            sample_cnt  <= '0;
            win_len_lat <= '0;
        end else begin
            trigger_d <= trigger;
            if (!enable) begin
                prod_i      <= '0;
                prod_q      <= '0;
                p_valid     <= 1'b0;
                p_last      <= 1'b0;
                sample_cnt  <= '0;
                win_len_lat <= '0;
            end else begin
                p_valid <= run_c & in_valid;
                p_last  <= last_c;
                if (run_c && in_valid) begin
                    for (int c = 0; c < int'(NUM_CH); c++) begin
                        prod_i[c] <= PROD_W'($signed(signal[c*SIG_W +: SIG_W])) * PROD_W'($signed(ref_i));
                        prod_q[c] <= PROD_W'($signed(signal[c*SIG_W +: SIG_W])) * PROD_W'($signed(ref_q));
                    end
                end
                if (start_c && mode) begin
                    sample_cnt  <= '0;
                    win_len_lat <= win_len_eff;
                end else if (run_c && mode && in_valid) begin
                    if (last_c) begin
                        sample_cnt  <= '0;
                        win_len_lat <= win_len_eff;
                    end else begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Stage 2 adder with clamp per channel
    always_comb begin
        sum_i_c = '0;
        sum_q_c = '0;
        clamp_c = '0;
        res_i   = '0;
        res_q   = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            res_i      = add_sat(acc_i[c], prod_i[c], p_valid);
            res_q      = add_sat(acc_q[c], prod_q[c], p_valid);
            sum_i_c[c] = res_i[ACC_W-1:0];
            sum_q_c[c] = res_q[ACC_W-1:0];
            clamp_c[c] = res_i[ACC_W] | res_q[ACC_W];
        end
    end

    // Stage 2: accumulate, dump on window close, output handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_i     <= '0;
            acc_q     <= '0;
            sat_acc   <= '0;
            win_cnt   <= '0;
            i_out     <= '0;
            q_out     <= '0;
            count_out <= '0;
            sat_out   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (!enable) begin
            acc_i   <= '0;
            acc_q   <= '0;
            sat_acc <= '0;
            win_cnt <= '0;
            overrun <= 1'b0;
            // a pending result can still be taken while disabled
            if (out_ready) out_valid <= 1'b0;
        end else if (p_last) begin
            i_out     <= sum_i_c;
            q_out     <= sum_q_c;
            count_out <= win_cnt + CNT_W'(p_valid);
            sat_out   <= sat_acc | clamp_c;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) overrun <= 1'b1;
            acc_i     <= '0;
            acc_q     <= '0;
            sat_acc   <= '0;
            win_cnt   <= '0;
        end else begin
            acc_i   <= sum_i_c;
            acc_q   <= sum_q_c;
            sat_acc <= sat_acc | clamp_c;
            win_cnt <= win_cnt + CNT_W'(p_valid);
            if (out_ready) out_valid <= 1'b0;
        end
    end

endmodule
